ccff_chain_loader: RTL and testbench

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

---
 rtl/ccff_chain_loader.sv | 112 +++++++++++
 tb/tb_ccff_chain_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams a word-wide bitstream LSB-first into a
// configuration flip-flop chain, with an optional second pass that compares
// the chain tail against the resent bitstream and counts mismatches.
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 44,
  parameter int unsigned WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_cnt
);

  localparam int unsigned       WCW       = $clog2(WORD_W + 1);
  localparam logic [15:0]       LAST_BIT  = 16'(CHAIN_LEN - 1);
  localparam logic [WCW-1:0]    LAST_WBIT = WCW'(WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [WORD_W-1:0] r_sreg;
  logic [15:0]       r_bit_cnt;
  logic [WCW-1:0]    r_wcnt;
  logic              r_pass;
  logic              r_vmode;
  logic [15:0]       r_err_cnt;

  logic              w_last_bit;
  logic              w_last_wbit;
  logic              w_mismatch;

  assign w_last_bit  = (r_bit_cnt == LAST_BIT);
  assign w_last_wbit = (r_wcnt == LAST_WBIT);
  assign w_mismatch  = r_pass && (ccff_tail != r_sreg[0]);

  // Output decode of the registered state; head is forced low outside SHIFT.
  assign data_ready    = (r_state == S_FETCH);
  assign ccff_shift_en = (r_state == S_SHIFT);
  assign ccff_head     = (r_state == S_SHIFT) && r_sreg[0];
  assign busy          = (r_state == S_FETCH) || (r_state == S_SHIFT);
  assign done          = (r_state == S_DONE);
  assign err_cnt       = r_err_cnt;

  // Load/verify sequencer: fetch a word, shift it out, repeat until the chain is full.
  always_ff @(posedge prog_clk) begin
    if (!prog_rst_n) begin
      r_state   <= S_IDLE;
      r_sreg    <= '0;
      r_bit_cnt <= '0;
      r_wcnt    <= '0;
      r_pass    <= 1'b0;
      r_vmode   <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state   <= S_FETCH;
            r_vmode   <= verify;
            r_pass    <= 1'b0;
            r_bit_cnt <= '0;
            r_err_cnt <= '0;
          end
        end
        S_FETCH: begin
          if (data_valid) begin
            r_sreg  <= data_in;
            r_wcnt  <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_sreg    <= r_sreg >> 1;
          r_bit_cnt <= r_bit_cnt + 16'd1;
          r_wcnt    <= r_wcnt + 1'b1;
          if (w_mismatch && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
          end
          // Chain-full takes precedence over word-end so a short final word
          // drops its unused upper bits.
          if (w_last_bit) begin
            if (r_vmode && !r_pass) begin
              r_pass    <= 1'b1;
              r_bit_cnt <= '0;
              r_state   <= S_FETCH;
            end else begin
              r_state <= S_DONE;
            end
          end else if (w_last_wbit) begin
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: the driver pushes the expected head
// bit stream and per-load completion results; a monitor checks them as the
// DUT shifts and when it reaches DONE.
module tb_ccff_chain_loader;

  localparam int CL = 44;
  localparam int WW = 8;
  localparam int NW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          verify = 1'b0;
  logic [WW-1:0] din = '0;
  logic          dv = 1'b0;
  logic          ready, head, sen, tail, busy, done;
  logic [15:0]   err;

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk      (clk),
    .prog_rst_n    (rst_n),
    .start         (start),
    .verify        (verify),
    .data_in       (din),
    .data_valid    (dv),
    .data_ready    (ready),
    .ccff_head     (head),
    .ccff_shift_en (sen),
    .ccff_tail     (tail),
    .busy          (busy),
    .done          (done),
    .err_cnt       (err)
  );

  always #5 clk = ~clk;

  // Target chain: head enters at the top, tail is bit 0; clock gated by shift enable.
  logic [CL-1:0] chain = '0;
  bit            inv_tail = 1'b0;
  always @(posedge clk) if (sen) chain <= {head, chain[CL-1:1]};
  assign tail = inv_tail ? ~chain[0] : chain[0];

  typedef struct {
    logic [15:0]   err;
    logic [CL-1:0] chain;
    int            pulses;
    int            words;
    int            cycles;
  } exp_t;

  bit   head_q[$];
  exp_t done_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [WW-1:0] w0[NW];
  logic [WW-1:0] w1[NW];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got event, required none", nm);
  endtask

  // Monitor: checks every shifted head bit and the result of every completed load.
  int   m_pulses = 0, m_words = 0, m_cyc = 0;
  bit   prev_busy = 1'b0, prev_done = 1'b0;
  bit   m_bit;
  exp_t m_e;
  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      m_pulses = 0;
      m_words  = 0;
      m_cyc    = 0;
    end
    if (busy) m_cyc++;
    if (sen) begin
      m_pulses++;
      if (head_q.size() == 0) fail_now("unexpected_shift");
      else begin
        m_bit = head_q.pop_front();
        check("head_bit", 64'(head), 64'(m_bit));
      end
    end
    if (dv && ready) m_words++;
    if (done && !prev_done) begin
      if (done_q.size() == 0) fail_now("unexpected_done");
      else begin
        m_e = done_q.pop_front();
        check("err_cnt", 64'(err), 64'(m_e.err));
        check("chain", 64'(chain), 64'(m_e.chain));
        check("shift_pulses", 64'(m_pulses), 64'(m_e.pulses));
        check("words_accepted", 64'(m_words), 64'(m_e.words));
        check("done_cycle", 64'(m_cyc + 1), 64'(m_e.cycles));
      end
    end
    prev_busy = busy;
    prev_done = done;
  end

  function automatic bit sbit(input logic [WW-1:0] w[NW], input int k);
    logic [WW-1:0] t;
    t = w[k / WW];
    return t[k % WW];
  endfunction

  // One full load: expectations from the word arrays, then drive the source.
  task automatic do_load(input bit vm, input bit inv, input int stall_at,
                         input int stall_len, input bit pulse_start, input bit chk_clear);
    exp_t e;
    int   nw, idx, scount, budget, pstate, t;
    bit   a, b, xfer, sen_now, stalling;
    e.err   = '0;
    e.chain = '0;
    for (int k = 0; k < CL; k++) begin
      a = sbit(w0, k);
      head_q.push_back(a);
      e.chain[k] = a;
    end
    if (vm) begin
      for (int k = 0; k < CL; k++) begin
        a = sbit(w0, k);
        b = sbit(w1, k);
        head_q.push_back(b);
        e.chain[k] = b;
        if (b != (a ^ inv)) e.err = e.err + 16'd1;
      end
    end
    nw       = vm ? 2 * NW : NW;
    e.pulses = vm ? 2 * CL : CL;
    e.words  = nw;
    e.cycles = e.pulses + e.words + stall_len + 1;
    done_q.push_back(e);

    inv_tail = inv;
    @(posedge clk); #1;
    start = 1'b1; verify = vm;
    @(posedge clk); #1;
    start = 1'b0; verify = 1'b0;
    if (chk_clear) begin
      check("restart_err_clear", 64'(err), 64'd0);
      check("restart_busy", 64'(busy), 64'd1);
    end

    idx = 0; scount = 0; budget = 0; pstate = 0; stalling = 1'b0;
    dv = 1'b1; din = w0[0];
    while (idx < nw && budget < 1000) begin
      @(negedge clk);
      budget++;
      xfer    = dv && ready;
      sen_now = sen;
      if (stalling && ready) begin
        check("stall_shift_en", 64'(sen), 64'd0);
        scount++;
      end
      @(posedge clk); #1;
      if (pstate == 1) begin start = 1'b0; verify = 1'b0; pstate = 2; end
      if (pulse_start && pstate == 0 && sen_now) begin start = 1'b1; verify = 1'b1; pstate = 1; end
      if (xfer) begin
        idx++;
        if (idx < nw) din = (idx < NW) ? w0[idx] : w1[idx - NW];
        if (idx == stall_at && stall_len > 0) begin dv = 1'b0; stalling = 1'b1; end
      end
      if (stalling && scount == stall_len) begin dv = 1'b1; stalling = 1'b0; end
    end
    dv = 1'b0; start = 1'b0; verify = 1'b0;
    if (idx < nw) fail_now("word_timeout");
    t = 0;
    while (!done && t < 200) begin @(posedge clk); #1; t++; end
    if (!done) fail_now("done_timeout");
  endtask

  // Reset after bit 20 of a load, with start also high on the reset edge.
  task automatic reset_mid_load();
    int  idx, pc, budget;
    bit  xfer;
    for (int i = 0; i < NW; i++) w0[i] = WW'($urandom);
    for (int k = 0; k < CL; k++) head_q.push_back(sbit(w0, k));
    inv_tail = 1'b0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    idx = 0; pc = 0; budget = 0;
    dv = 1'b1; din = w0[0];
    while (pc < 20 && budget < 200) begin
      @(negedge clk);
      budget++;
      xfer = dv && ready;
      if (sen) pc++;
      @(posedge clk); #1;
      if (xfer) begin idx++; if (idx < NW) din = w0[idx]; end
    end
    if (pc < 20) fail_now("reset_setup_timeout");
    rst_n = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_shift_en", 64'(sen), 64'd0);
    check("rst_mid_err", 64'(err), 64'd0);
    check("rst_mid_ready", 64'(ready), 64'd0);
    dv = 1'b0;
    head_q.delete();
    repeat (3) @(posedge clk);
    #1 check("rst_mid_idle_shift_en", 64'(sen), 64'd0);
  endtask

  initial begin
    // Reset with start and data_valid held: reset must win.
    rst_n = 1'b0; start = 1'b1; dv = 1'b1; din = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_head", 64'(head), 64'd0);
    check("rst_shift_en", 64'(sen), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_ready_with_valid", 64'(ready), 64'd0);
    check("idle_shift_en", 64'(sen), 64'd0);
    dv = 1'b0;

    // Basic load of 0x01..0x06.
    for (int i = 0; i < NW; i++) w0[i] = WW'(i + 1);
    do_load(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    // Matching verify, started from DONE.
    for (int i = 0; i < NW; i++) w1[i] = w0[i];
    do_load(1'b1, 1'b0, 0, 0, 1'b0, 1'b1);

    // Second pass word 0 differs in one bit.
    w1[0] = 8'h00;
    do_load(1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("done_hold", 64'(done), 64'd1);
    check("done_err_stable", 64'(err), 64'd1);

    // Inverted tail: every pass-1 bit mismatches.
    w1[0] = w0[0];
    do_load(1'b1, 1'b1, 0, 0, 1'b0, 1'b1);

    // Five-cycle stall between words 3 and 4.
    do_load(1'b0, 1'b0, 3, 5, 1'b0, 1'b1);

    // Start pulsed while shifting.
    do_load(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);

    // Reset mid-load, then a full load.
    reset_mid_load();
    do_load(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    // Randomized loads.
    for (int r = 0; r < 8; r++) begin
      int sa, sl;
      bit vm, inv;
      for (int i = 0; i < NW; i++) begin
        w0[i] = WW'($urandom);
        w1[i] = w0[i] ^ (($urandom_range(2, 0) == 0) ? WW'(1 << $urandom_range(WW - 1, 0)) : WW'(0));
      end
      vm  = 1'($urandom_range(1, 0));
      inv = vm && ($urandom_range(3, 0) == 0);
      sl  = ($urandom_range(1, 0) == 1) ? $urandom_range(6, 1) : 0;
      sa  = $urandom_range(NW - 1, 1);
      do_load(vm, inv, sa, sl, 1'($urandom_range(1, 0)), 1'b1);
    end

    repeat (5) @(posedge clk);
    #1;
    check("head_queue_drained", 64'(head_q.size()), 64'd0);
    check("done_queue_drained", 64'(done_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
